// File: rtl/bp_common_pkg.sv
// bp_common_pkg: shared types and constants for the softcore memory arbiter.
//   bp_params_e        processor configuration selector
//   bp_cce_mem_msg_s   memory command/response message
//   bp_dev_e           device index (mem / io / clint)
//   host_dev_gp, clint_dev_gp, local_region_bound_gp: local address map
package bp_common_pkg;

    typedef enum logic [0:0] {
        e_bp_inv_cfg = 1'b0
    } bp_params_e;

    localparam int unsigned paddr_width_gp = 40;
    localparam int unsigned num_dev_gp     = 3;

    // Device group ids live in addr[23:20] of the local region.
    localparam logic [3:0] host_dev_gp  = 4'h1;
    localparam logic [3:0] clint_dev_gp = 4'h3;

    // Addresses below this bound belong to the local (device) region.
    localparam logic [paddr_width_gp-1:0] local_region_bound_gp = 40'h00_8000_0000;

    typedef enum logic [1:0] {
        e_dev_mem   = 2'd0,
        e_dev_io    = 2'd1,
        e_dev_clint = 2'd2
    } bp_dev_e;

    typedef struct packed {
        logic [3:0]                msg_type;
        logic [3:0]                lce_id;
        logic [paddr_width_gp-1:0] addr;
        logic [63:0]               data;
    } bp_cce_mem_msg_s;

    // Message width for a given configuration.
    function automatic int unsigned bp_mem_msg_width(bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg: return $bits(bp_cce_mem_msg_s);
            default:      return $bits(bp_cce_mem_msg_s);
        endcase
    endfunction

endpackage

// File: rtl/bp_softcore_mem_arbiter_if.sv
// bp_softcore_mem_arbiter_if: requester and device handshake bundle.
//   req_cmd_*   requester commands, ready-valid
//   req_resp_*  requester responses, valid-yumi
//   dev_cmd_*   device commands (index 0=mem, 1=io, 2=clint), ready-valid
//   dev_resp_*  device responses, valid-yumi
// Modport slave is the arbiter; master is the surrounding requesters/devices.
interface bp_softcore_mem_arbiter_if #(
    parameter int unsigned num_req_p = 2
) ();
    import bp_common_pkg::*;

    bp_cce_mem_msg_s [num_req_p-1:0]  req_cmd_i;
    logic            [num_req_p-1:0]  req_cmd_v_i;
    logic            [num_req_p-1:0]  req_cmd_ready_o;

    bp_cce_mem_msg_s [num_req_p-1:0]  req_resp_o;
    logic            [num_req_p-1:0]  req_resp_v_o;
    logic            [num_req_p-1:0]  req_resp_yumi_i;

    bp_cce_mem_msg_s [num_dev_gp-1:0] dev_cmd_o;
    logic            [num_dev_gp-1:0] dev_cmd_v_o;
    logic            [num_dev_gp-1:0] dev_cmd_ready_i;

    bp_cce_mem_msg_s [num_dev_gp-1:0] dev_resp_i;
    logic            [num_dev_gp-1:0] dev_resp_v_i;
    logic            [num_dev_gp-1:0] dev_resp_yumi_o;

    modport slave (
        input  req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
        input  dev_cmd_ready_i, dev_resp_i, dev_resp_v_i,
        output req_cmd_ready_o, req_resp_o, req_resp_v_o,
        output dev_cmd_o, dev_cmd_v_o, dev_resp_yumi_o
    );

    modport master (
        output req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
        output dev_cmd_ready_i, dev_resp_i, dev_resp_v_i,
        input  req_cmd_ready_o, req_resp_o, req_resp_v_o,
        input  dev_cmd_o, dev_cmd_v_o, dev_resp_yumi_o
    );

endinterface

// File: rtl/bp_local_addr_decode.sv
// bp_local_addr_decode: maps a physical address to its target device.
//   addr_i  physical address
//   dev_o   e_dev_io / e_dev_clint inside the local region, else e_dev_mem
module bp_local_addr_decode
    import bp_common_pkg::*;
(
    input  logic [paddr_width_gp-1:0] addr_i,
    output bp_dev_e                   dev_o
);

    always_comb begin
        dev_o = e_dev_mem;
        if (addr_i < local_region_bound_gp) begin
            if (addr_i[23:20] == host_dev_gp) begin
                dev_o = e_dev_io;
            end else if (addr_i[23:20] == clint_dev_gp) begin
                dev_o = e_dev_clint;
            end
        end
    end

endmodule

// File: rtl/bp_softcore_mem_arbiter.sv
// bp_softcore_mem_arbiter: round-robin arbitration of requester commands onto
// three devices (mem/io/clint) through a one-entry output register, plus a
// combinational priority response path steered back by lce_id.
//   clk_i, reset_n_i  clock, asynchronous active-low reset
//   bus               handshake bundle (slave modport)
//   credits_full_o    per-requester outstanding count == max_outstanding_p
//   credits_empty_o   per-requester outstanding count == 0
//   err_o             sticky: a response carried an out-of-range lce_id
module bp_softcore_mem_arbiter
    import bp_common_pkg::*;
#(
    parameter bp_params_e  bp_params_p       = e_bp_inv_cfg,
    parameter int unsigned num_req_p         = 2,
    parameter int unsigned max_outstanding_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_softcore_mem_arbiter_if.slave bus,
    output logic [num_req_p-1:0]     credits_full_o,
    output logic [num_req_p-1:0]     credits_empty_o,
    output logic                     err_o
);

    localparam int unsigned MsgW = bp_mem_msg_width(bp_params_p);
    localparam int unsigned CntW = $clog2(max_outstanding_p + 1);
    localparam int unsigned IdxW = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(max_outstanding_p);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e            state_q, state_d;
    logic [MsgW-1:0]   cmd_q, cmd_d;
    bp_dev_e           dev_q, dev_d;
    logic [IdxW-1:0]   rr_q, rr_d;
    logic [CntW-1:0]   cnt_q [num_req_p];
    logic [CntW-1:0]   cnt_d [num_req_p];
    logic              err_q, err_d;

    logic [num_req_p-1:0] eligible, inc, dec;
    logic                 grant_v, grant, load_slot;
    logic [IdxW-1:0]      grant_idx;
    int unsigned          rr_cand, rr_nxt;
    bp_cce_mem_msg_s      grant_cmd;
    bp_dev_e              grant_dev;

    bp_dev_e              resp_sel;
    bp_cce_mem_msg_s      resp_msg;
    logic                 resp_v, resp_legal, resp_yumi_req;

    // Round-robin search starting at rr_q over requesters that still have credit.
    always_comb begin
        rr_cand   = 0;
        grant_v   = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            eligible[i] = bus.req_cmd_v_i[i] && (cnt_q[i] < CntMax);
        end
        for (int unsigned k = 0; k < num_req_p; k++) begin
            rr_cand = (32'(rr_q) + k) % num_req_p;
            if (!grant_v && eligible[rr_cand]) begin
                grant_v   = 1'b1;
                grant_idx = IdxW'(rr_cand);
            end
        end
    end

    // The register can take a new command when empty or when it drains this cycle.
    assign load_slot = (state_q == StIdle) || bus.dev_cmd_ready_i[dev_q];
    assign grant     = grant_v && load_slot;
    assign grant_cmd = bus.req_cmd_i[grant_idx];

    bp_local_addr_decode u_decode (
        .addr_i (grant_cmd.addr),
        .dev_o  (grant_dev)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (grant) state_d = StBusy;
            StBusy: if (bus.dev_cmd_ready_i[dev_q]) state_d = grant ? StBusy : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: command register towards the devices, grant towards requesters.
    always_comb begin
        bus.dev_cmd_v_o     = '0;
        bus.req_cmd_ready_o = '0;
        for (int unsigned d = 0; d < num_dev_gp; d++) begin
            bus.dev_cmd_o[d] = cmd_q;
        end
        if (reset_n_i && (state_q == StBusy)) begin
            bus.dev_cmd_v_o[dev_q] = 1'b1;
        end
        if (reset_n_i && grant) begin
            bus.req_cmd_ready_o[grant_idx] = 1'b1;
        end
    end

    // Datapath and credit next state.
    always_comb begin
        rr_nxt = (32'(grant_idx) + 1) % num_req_p;
        cmd_d  = grant ? grant_cmd : cmd_q;
        dev_d  = grant ? grant_dev : dev_q;
        rr_d   = grant ? IdxW'(rr_nxt) : rr_q;
        err_d  = err_q | (resp_v & ~resp_legal);
        for (int unsigned i = 0; i < num_req_p; i++) begin
            inc[i]   = grant && (grant_idx == IdxW'(i));
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!inc[i] && dec[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_q <= '0;
            dev_q <= e_dev_mem;
            rr_q  <= '0;
            err_q <= 1'b0;
            for (int unsigned i = 0; i < num_req_p; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cmd_q <= cmd_d;
            dev_q <= dev_d;
            rr_q  <= rr_d;
            err_q <= err_d;
            for (int unsigned i = 0; i < num_req_p; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Response path: pick clint > io > mem, steer to lce_id; illegal ids are dropped.
    always_comb begin
        resp_sel = e_dev_mem;
        if (bus.dev_resp_v_i[e_dev_clint]) begin
            resp_sel = e_dev_clint;
        end else if (bus.dev_resp_v_i[e_dev_io]) begin
            resp_sel = e_dev_io;
        end
        resp_v        = |bus.dev_resp_v_i;
        resp_msg      = bus.dev_resp_i[resp_sel];
        resp_legal    = 32'(resp_msg.lce_id) < num_req_p;
        resp_yumi_req = 1'b0;
        dec           = '0;
        bus.req_resp_v_o    = '0;
        bus.dev_resp_yumi_o = '0;
        for (int unsigned i = 0; i < num_req_p; i++) begin
            bus.req_resp_o[i] = resp_msg;
            if (resp_v && (32'(resp_msg.lce_id) == i)) begin
                dec[i]                = bus.req_resp_yumi_i[i];
                resp_yumi_req         = bus.req_resp_yumi_i[i];
                bus.req_resp_v_o[i]   = reset_n_i;
            end
        end
        if (reset_n_i && resp_v) begin
            bus.dev_resp_yumi_o[resp_sel] = resp_legal ? resp_yumi_req : 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < num_req_p; i++) begin
            credits_full_o[i]  = reset_n_i && (cnt_q[i] == CntMax);
            credits_empty_o[i] = !reset_n_i || (cnt_q[i] == '0);
        end
    end

    assign err_o = reset_n_i && err_q;

    for (genvar g = 0; g < num_req_p; g++) begin : g_cnt_chk
        a_no_overflow : assert property (@(posedge clk_i) disable iff (!reset_n_i)
            !(inc[g] && !dec[g] && (cnt_q[g] == CntMax)));
        a_no_underflow : assert property (@(posedge clk_i) disable iff (!reset_n_i)
            !(dec[g] && !inc[g] && (cnt_q[g] == '0)));
    end

endmodule
